// File: rtl/r_burst_sender.sv
// r_burst_sender
// AXI read-data channel sender. Accepts one burst command (id, beats-1, resp),
// then turns a stream of data words into R beats with valid/ready handshake,
// generating r_last on the final beat and holding every r_* output stable
// while the receiver stalls.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*   burst command channel (id, len = beats-1, resp)
//   din_valid/ready/data     data word stream, one word per beat
//   r_valid/ready, r_*       R beat output register
//   busy                     burst in progress or a beat still pending
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command; data input is not consumed
// S_BURST | loading data words into the R register until the last beat
module r_burst_sender #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [RESP_WIDTH-1:0] cmd_resp,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_data,
    output logic                  r_valid,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [RESP_WIDTH-1:0] r_resp,
    output logic                  r_last,
    input  logic                  r_ready,
    output logic                  busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [RESP_WIDTH-1:0] resp_q, resp_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic                  r_valid_q, r_valid_d;
    logic                  r_last_q, r_last_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [RESP_WIDTH-1:0] r_resp_q, r_resp_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            len_q      <= '0;
            resp_q     <= '0;
            beat_cnt_q <= '0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            len_q      <= len_d;
            resp_q     <= resp_d;
            beat_cnt_q <= beat_cnt_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        len_d      = len_q;
        resp_d     = resp_q;
        beat_cnt_d = beat_cnt_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_id_d     = r_id_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        cmd_ready  = 1'b0;
        din_ready  = 1'b0;

        // Accepted beat drains unless a load below replaces it in the same cycle.
        if (r_valid_q && r_ready) begin
            r_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    id_d       = cmd_id;
                    len_d      = cmd_len;
                    resp_d     = cmd_resp;
                    beat_cnt_d = '0;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                // Register is free when empty or being drained this cycle.
                din_ready = !r_valid_q || r_ready;
                if (din_valid && din_ready) begin
                    r_valid_d  = 1'b1;
                    r_data_d   = din_data;
                    r_id_d     = id_q;
                    r_resp_d   = resp_q;
                    // Equality compare keeps len = all-ones safe when the counter wraps.
                    r_last_d   = (beat_cnt_q == len_q);
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign r_valid = r_valid_q;
    assign r_last  = r_last_q;
    assign r_id    = r_id_q;
    assign r_data  = r_data_q;
    assign r_resp  = r_resp_q;
    assign busy    = (state_q == S_BURST) || r_valid_q;

endmodule

// File: tb/tb_r_burst_sender.sv
module tb_r_burst_sender;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam int RW = 2;
    localparam int LW = 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [RW-1:0] resp;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [LW-1:0] len;
        logic [RW-1:0] resp;
    } cmd_t;

    logic          clk, rst;
    logic          cmd_valid, cmd_ready;
    logic [IW-1:0] cmd_id;
    logic [LW-1:0] cmd_len;
    logic [RW-1:0] cmd_resp;
    logic          din_valid, din_ready;
    logic [DW-1:0] din_data;
    logic          r_valid, r_last, r_ready, busy;
    logic [IW-1:0] r_id;
    logic [DW-1:0] r_data;
    logic [RW-1:0] r_resp;

    r_burst_sender #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_len(cmd_len), .cmd_resp(cmd_resp),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .r_valid(r_valid), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_ready(r_ready), .busy(busy)
    );

    // Reference model: the expected beat stream is every queued burst in order,
    // one beat per data word, id/resp from its command, last on word len.
    beat_t         exp_q[$];
    cmd_t          cmd_q[$];
    logic [DW-1:0] din_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cmd_hs_cyc = 0;
    bit din_auto = 1'b1;
    bit rr_auto  = 1'b1;
    int din_pct  = 100;
    int rr_pct   = 100;

    bit    prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t m_got, m_exp;
    cmd_t  m_cmd;
    logic [DW-1:0] m_word;

    int            d_cyc[$];
    logic [IW-1:0] d_id[$];
    bit            d_last[$];
    logic [RW-1:0] d_resp[$];
    bit            d_crdy[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and handshake bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready && cmd_q.size() > 0) begin
                m_cmd = cmd_q.pop_front();
                cmd_hs_cyc = cyc;
            end
            if (din_valid && din_ready && din_q.size() > 0) begin
                m_word = din_q.pop_front();
            end
            m_got = {r_id, r_data, r_resp, r_last};
            if (r_valid && r_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected got=%h required=none", m_got);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (m_got !== m_exp) begin
                        bad++;
                        $display("FAIL beat_content got=%h required=%h", m_got, m_exp);
                    end
                end
            end
            if (prev_stall) begin
                total++;
                if (r_valid !== 1'b1 || m_got !== prev_beat) begin
                    bad++;
                    $display("FAIL stall_hold got=%b/%h required=1/%h", r_valid, m_got, prev_beat);
                end
            end
            prev_stall = r_valid && !r_ready;
            prev_beat  = m_got;
            total++;
            if (cmd_ready && din_ready) begin
                bad++;
                $display("FAIL din_ready_idle got=1 required=0");
            end
            total++;
            if (busy !== (!cmd_ready || r_valid)) begin
                bad++;
                $display("FAIL busy got=%b required=%b", busy, (!cmd_ready || r_valid));
            end
        end
    end

    task automatic drivers();
        forever begin
            @(posedge clk);
            #1;
            if (cmd_q.size() > 0) begin
                cmd_valid = 1'b1;
                cmd_id    = cmd_q[0].id;
                cmd_len   = cmd_q[0].len;
                cmd_resp  = cmd_q[0].resp;
            end else begin
                cmd_valid = 1'b0;
                cmd_id    = '0;
                cmd_len   = '0;
                cmd_resp  = '0;
            end
            if (din_auto) begin
                if (din_q.size() > 0 && $urandom_range(99) < din_pct) begin
                    din_valid = 1'b1;
                    din_data  = din_q[0];
                end else begin
                    din_valid = 1'b0;
                end
            end
            if (rr_auto) r_ready = ($urandom_range(99) < rr_pct);
        end
    endtask

    task automatic queue_burst(input logic [IW-1:0] id, input logic [LW-1:0] len,
                               input logic [RW-1:0] resp, input bit fixed,
                               input logic [DW-1:0] fdata);
        cmd_t c;
        beat_t b;
        logic [DW-1:0] w;
        c.id = id; c.len = len; c.resp = resp;
        cmd_q.push_back(c);
        for (int i = 0; i <= int'(len); i++) begin
            w = fixed ? fdata : {$urandom, $urandom};
            din_q.push_back(w);
            b.id = id; b.data = w; b.resp = resp; b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    // Runs until the model is empty and the DUT idle, logging accepted beats.
    task automatic drain(input int budget, output bit timeout);
        d_cyc.delete(); d_id.delete(); d_last.delete(); d_resp.delete(); d_crdy.delete();
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (r_valid && r_ready) begin
                d_cyc.push_back(cyc);
                d_id.push_back(r_id);
                d_last.push_back(r_last);
                d_resp.push_back(r_resp);
                d_crdy.push_back(cmd_ready);
            end
            if (cmd_q.size() == 0 && exp_q.size() == 0 && !busy) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({r_valid, r_last, r_id, r_data, r_resp} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0", {r_valid, r_last, r_id, r_data, r_resp});
        end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b required=1", cmd_ready); end
        total++;
        if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_din_ready got=%b required=0", din_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        bit to;
        rr_auto = 1'b1; rr_pct = 100; din_pct = 100;
        queue_burst(4'd3, 8'd0, 2'd0, 1'b1, 64'hA5);
        drain(50, to);
        total++;
        if (to || d_cyc.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d timeout=%0d required=1", d_cyc.size(), to);
        end else begin
            total++;
            if (d_id[0] !== 4'd3 || d_last[0] !== 1'b1) begin
                bad++;
                $display("FAIL single_beat got id=%0d last=%0d required id=3 last=1", d_id[0], d_last[0]);
            end
            total++;
            if (d_crdy[0] !== 1'b1) begin bad++; $display("FAIL single_cmd_ready got=%b required=1", d_crdy[0]); end
            total++;
            if (d_cyc[0] - cmd_hs_cyc != 2) begin
                bad++;
                $display("FAIL single_latency got=%0d required=2", d_cyc[0] - cmd_hs_cyc);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        bit seen = 1'b0;
        int lasts = 0;
        rr_auto = 1'b0; r_ready = 1'b0; din_pct = 100;
        queue_burst(4'd5, 8'd3, 2'd0, 1'b0, '0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = r_valid;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL stall_first_beat got=none required=beat"); end
        total++;
        if (din_ready !== 1'b0) begin bad++; $display("FAIL stall_din_ready1 got=%b required=0", din_ready); end
        @(negedge clk);
        total++;
        if (din_ready !== 1'b0) begin bad++; $display("FAIL stall_din_ready2 got=%b required=0", din_ready); end
        @(posedge clk);
        #1 r_ready = 1'b1;
        drain(50, to);
        foreach (d_last[i]) lasts += int'(d_last[i]);
        total++;
        if (to || d_cyc.size() != 4 || lasts != 1 || d_last[3] !== 1'b1) begin
            bad++;
            $display("FAIL stall_beats got=%0d lasts=%0d timeout=%0d required=4/1", d_cyc.size(), lasts, to);
        end
        rr_auto = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [IW-1:0] ids[5];
        bit lst[5];
        int gaps[4];
        ids = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
        lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        gaps = '{1, 2, 1, 1};
        rr_auto = 1'b1; rr_pct = 100; din_pct = 100;
        queue_burst(4'd1, 8'd1, 2'd0, 1'b0, '0);
        queue_burst(4'd2, 8'd2, 2'd0, 1'b0, '0);
        drain(60, to);
        total++;
        if (to || d_cyc.size() != 5) begin
            bad++;
            $display("FAIL b2b_count got=%0d timeout=%0d required=5", d_cyc.size(), to);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (d_id[i] !== ids[i] || d_last[i] !== lst[i]) begin
                    bad++;
                    $display("FAIL b2b_beat%0d got id=%0d last=%0d required id=%0d last=%0d",
                             i, d_id[i], d_last[i], ids[i], lst[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (d_cyc[i+1] - d_cyc[i] != gaps[i]) begin
                    bad++;
                    $display("FAIL b2b_gap%0d got=%0d required=%0d", i, d_cyc[i+1] - d_cyc[i], gaps[i]);
                end
            end
        end
    endtask

    task automatic test_max_len();
        bit to;
        int lasts = 0;
        rr_auto = 1'b1; rr_pct = 100; din_pct = 100;
        queue_burst(4'd7, 8'd255, 2'd1, 1'b0, '0);
        drain(400, to);
        foreach (d_last[i]) lasts += int'(d_last[i]);
        total++;
        if (to || d_cyc.size() != 256 || lasts != 1) begin
            bad++;
            $display("FAIL maxlen_count got=%0d lasts=%0d timeout=%0d required=256/1", d_cyc.size(), lasts, to);
        end else begin
            total++;
            if (d_last[255] !== 1'b1 || d_cyc[255] - d_cyc[0] != 255) begin
                bad++;
                $display("FAIL maxlen_stream got last=%0d span=%0d required last=1 span=255",
                         d_last[255], d_cyc[255] - d_cyc[0]);
            end
        end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL maxlen_idle got=%b required=1", cmd_ready); end
        queue_burst(4'd8, 8'd0, 2'd0, 1'b0, '0);
        drain(30, to);
        total++;
        if (to || d_cyc.size() != 1) begin
            bad++;
            $display("FAIL maxlen_after got=%0d timeout=%0d required=1", d_cyc.size(), to);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        int got = 0;
        rr_auto = 1'b1; rr_pct = 100; din_pct = 100;
        queue_burst(4'd6, 8'd7, 2'd0, 1'b0, '0);
        for (int i = 0; i < 30 && got < 2; i++) begin
            @(negedge clk);
            if (r_valid && r_ready) got++;
        end
        total++;
        if (got != 2) begin bad++; $display("FAIL midrst_prebeats got=%0d required=2", got); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cmd_q.delete(); din_q.delete(); exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (r_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state got v=%b cr=%b busy=%b required 0/1/0", r_valid, cmd_ready, busy);
        end
        queue_burst(4'd9, 8'd0, 2'd0, 1'b0, '0);
        drain(30, to);
        total++;
        if (to || d_cyc.size() != 1 || d_id[0] !== 4'd9) begin
            bad++;
            $display("FAIL midrst_after got=%0d timeout=%0d required=1 beat id=9", d_cyc.size(), to);
        end
    endtask

    task automatic test_idle_din_and_resp();
        bit to;
        int nresp = 0;
        din_auto = 1'b0;
        din_valid = 1'b1;
        din_data = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (din_ready !== 1'b0 || r_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_din got dr=%b rv=%b required 0/0", din_ready, r_valid);
            end
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
        din_auto = 1'b1;
        queue_burst(4'($urandom_range(15)), 8'd2, 2'd2, 1'b0, '0);
        drain(40, to);
        foreach (d_resp[i]) if (d_resp[i] === 2'd2) nresp++;
        total++;
        if (to || d_cyc.size() != 3 || nresp != 3) begin
            bad++;
            $display("FAIL slverr_resp got beats=%0d resp2=%0d timeout=%0d required=3/3", d_cyc.size(), nresp, to);
        end
    endtask

    task automatic test_random();
        bit to;
        int exp_beats = 0;
        int lasts = 0;
        logic [LW-1:0] len;
        rr_auto = 1'b1; rr_pct = 60; din_pct = 70;
        for (int n = 0; n < 25; n++) begin
            len = LW'($urandom_range(15));
            exp_beats += int'(len) + 1;
            queue_burst(IW'($urandom), len, RW'($urandom), 1'b0, '0);
        end
        drain(3000, to);
        foreach (d_last[i]) lasts += int'(d_last[i]);
        total++;
        if (to || d_cyc.size() != exp_beats || lasts != 25) begin
            bad++;
            $display("FAIL random_stream got beats=%0d lasts=%0d timeout=%0d required=%0d/25",
                     d_cyc.size(), lasts, to, exp_beats);
        end
        rr_pct = 100; din_pct = 100;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0; cmd_resp = '0;
        din_valid = 1'b0; din_data = '0; r_ready = 1'b1;
        fork
            drivers();
        join_none
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_max_len();
        test_reset_mid_burst();
        test_idle_din_and_resp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
